muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execute unit. It sits beside the single-cycle ALU in the Execute stage.
- It decodes funct3 for the eight M-extension ops (funct7 = 0000001). The ALU control path raises in_valid only for those ops.
- It runs a radix-2^BPC shift-add / restoring-divide loop over several cycles and holds the pipeline via busy.
- Results return through a valid/ready handshake to the Memory-stage register.

---
 rtl/riscv_pkg.sv | 28 ++
 rtl/muldiv_step.sv | 51 +++++
 rtl/muldiv_unit.sv | 183 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RV32M decode constants and multiply/divide state type.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } md_state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_step
// Description : One iteration of the iterative unit: BPC shift-add multiply
//               steps or BPC restoring-divide steps.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step #(
    parameter int XLEN = 32,
    parameter int BPC  = 1
) (
    input  logic            is_div,
    input  logic [XLEN:0]   hi_in,
    input  logic [XLEN-1:0] lo_in,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN:0]   hi_out,
    output logic [XLEN-1:0] lo_out
);

    logic [XLEN:0]   h;
    logic [XLEN-1:0] l;
    logic [XLEN:0]   sum;
    logic [XLEN+1:0] diff;

    always_comb begin
        h    = hi_in;
        l    = lo_in;
        sum  = '0;
        diff = '0;
        for (int i = 0; i < BPC; i++) begin
            if (is_div) begin
                // Trial subtract; quotient bit enters lo from the right.
                diff = {h, l[XLEN-1]} - {2'b00, operand};
                if (diff[XLEN+1]) begin
                    h = {h[XLEN-1:0], l[XLEN-1]};
                end else begin
                    h = diff[XLEN:0];
                end
                l = {l[XLEN-2:0], ~diff[XLEN+1]};
            end else begin
                sum = {1'b0, h[XLEN-1:0]} + {1'b0, (l[0] ? operand : '0)};
                h   = {1'b0, sum[XLEN:1]};
                l   = {sum[0], l[XLEN-1:1]};
            end
        end
        hi_out = h;
        lo_out = l;
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide execute unit with
//               valid/ready result handshake and flush support.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import riscv_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int BPC          = 1,
    parameter int FAST_SPECIAL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            busy
);

    localparam int              STEPS    = XLEN / BPC;
    localparam int              CNT_W    = $clog2(STEPS + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(STEPS);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_t         state, state_nxt;
    logic [2:0]        op;
    logic              res_neg;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN:0]     hi;
    logic [XLEN-1:0]   lo;
    logic [XLEN-1:0]   opb;
    logic [XLEN-1:0]   result;

    logic              accept;
    logic              is_div, a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf, special, go_fast, sign_in;
    logic [XLEN-1:0]   special_res;
    logic [XLEN:0]     step_hi;
    logic [XLEN-1:0]   step_lo;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

    assign accept = in_valid && (state == IDLE) && !flush;

    // Operand decode on the request itself; only consumed at accept.
    always_comb begin
        is_div   = funct3[2];
        a_signed = is_div ? !funct3[0] : (funct3 != F3_MULHU);
        b_signed = is_div ? !funct3[0] : (funct3 == F3_MULH);
        a_neg    = a_signed && rs1[XLEN-1];
        b_neg    = b_signed && rs2[XLEN-1];
        a_mag    = a_neg ? -rs1 : rs1;
        b_mag    = b_neg ? -rs2 : rs2;
        div_zero = is_div && (rs2 == '0);
        div_ovf  = is_div && !funct3[0] && (rs1 == MOST_NEG) && (rs2 == '1);
        special  = div_zero || div_ovf;
        go_fast  = (FAST_SPECIAL != 0) && special;
        // Quotient of x/0 is all-ones regardless of operand signs.
        if (!is_div) begin
            sign_in = a_neg ^ b_neg;
        end else if (funct3[1]) begin
            sign_in = a_neg;
        end else begin
            sign_in = (a_neg ^ b_neg) && !div_zero;
        end
        if (div_zero) begin
            special_res = funct3[1] ? rs1 : '1;
        end else begin
            special_res = funct3[1] ? '0 : rs1;
        end
    end

    muldiv_step #(
        .XLEN (XLEN),
        .BPC  (BPC)
    ) u_step (
        .is_div  (op[2]),
        .hi_in   (hi),
        .lo_in   (lo),
        .operand (opb),
        .hi_out  (step_hi),
        .lo_out  (step_lo)
    );

    always_comb begin
        prod     = {hi[XLEN-1:0], lo};
        prod_fix = res_neg ? -prod : prod;
        quo_fix  = res_neg ? -lo : lo;
        rem_fix  = res_neg ? -hi[XLEN-1:0] : hi[XLEN-1:0];
        case (op)
            F3_MUL:                     fix_res = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:            fix_res = quo_fix;
            default:                    fix_res = rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (accept) begin
                    state_nxt = go_fast ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = FIXUP;
                end
            end
            FIXUP: begin
                state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (flush) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op      <= '0;
            res_neg <= 1'b0;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            opb     <= '0;
            result  <= '0;
        end else if (accept) begin
            op      <= funct3;
            res_neg <= sign_in;
            cnt     <= CNT_INIT;
            hi      <= '0;
            lo      <= a_mag;
            opb     <= b_mag;
            if (go_fast) begin
                result <= special_res;
            end
        end else if (state == CALC) begin
            hi  <= step_hi;
            lo  <= step_lo;
            cnt <= cnt - CNT_W'(1);
        end else if (state == FIXUP) begin
            result <= fix_res;
        end
    end

    assign out_result = result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed self-checking bench for muldiv_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
    import riscv_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        busy;

    int checks;
    int errors;

    muldiv_unit #(
        .XLEN         (32),
        .BPC          (1),
        .FAST_SPECIAL (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .funct3     (funct3),
        .rs1        (rs1),
        .rs2        (rs2),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request, scramble inputs after accept, wait (bounded) for the result.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input bit pop, output logic [31:0] res, output int lat,
                          output bit busy_ok);
        in_valid = 1'b1;
        funct3   = f3;
        rs1      = a;
        rs2      = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        funct3   = ~f3;
        rs1      = 32'hDEAD_BEEF;
        rs2      = 32'h1234_5678;
        lat      = 1;
        busy_ok  = busy;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
            busy_ok = busy_ok & busy;
        end
        res = out_result;
        if (pop) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL reset_out_result got=%h exp=0", out_result); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        logic [31:0] res; int lat; bit bok;
        run_op(F3_MUL, 32'd7, 32'hFFFF_FFFD, 1'b1, res, lat, bok);
        checks++; if (res !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result got=%h exp=ffffffeb", res); end
        checks++; if (lat !== 34) begin errors++; $display("FAIL mul_latency got=%0d exp=34", lat); end
        checks++; if (bok !== 1'b1) begin errors++; $display("FAIL mul_busy got=%b exp=1", bok); end
        run_op(F3_MULH, 32'h8000_0000, 32'h8000_0000, 1'b1, res, lat, bok);
        checks++; if (res !== 32'h4000_0000) begin errors++; $display("FAIL mulh got=%h exp=40000000", res); end
        run_op(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, res, lat, bok);
        checks++; if (res !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhu got=%h exp=fffffffe", res); end
        run_op(F3_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, res, lat, bok);
        checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mulhsu got=%h exp=ffffffff", res); end
        run_op(F3_MULH, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, res, lat, bok);
        checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mulh_neg got=%h exp=ffffffff", res); end
    endtask

    task automatic test_div();
        logic [31:0] res; int lat; bit bok;
        run_op(F3_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, res, lat, bok);
        checks++; if (res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div got=%h exp=fffffffd", res); end
        checks++; if (lat !== 34) begin errors++; $display("FAIL div_latency got=%0d exp=34", lat); end
        run_op(F3_REM, 32'hFFFF_FFF9, 32'd2, 1'b1, res, lat, bok);
        checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem got=%h exp=ffffffff", res); end
        run_op(F3_DIVU, 32'hFFFF_FFF9, 32'd2, 1'b1, res, lat, bok);
        checks++; if (res !== 32'h7FFF_FFFC) begin errors++; $display("FAIL divu got=%h exp=7ffffffc", res); end
        run_op(F3_REMU, 32'd100, 32'd7, 1'b1, res, lat, bok);
        checks++; if (res !== 32'd2) begin errors++; $display("FAIL remu got=%h exp=2", res); end
    endtask

    task automatic test_special();
        logic [31:0] res; int lat; bit bok;
        run_op(F3_DIVU, 32'd5, 32'd0, 1'b1, res, lat, bok);
        checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_zero got=%h exp=ffffffff", res); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL divu_zero_latency got=%0d exp=1", lat); end
        run_op(F3_REMU, 32'd5, 32'd0, 1'b1, res, lat, bok);
        checks++; if (res !== 32'd5) begin errors++; $display("FAIL remu_zero got=%h exp=5", res); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL remu_zero_latency got=%0d exp=1", lat); end
        run_op(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, res, lat, bok);
        checks++; if (res !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf got=%h exp=80000000", res); end
        run_op(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, res, lat, bok);
        checks++; if (res !== 32'h0) begin errors++; $display("FAIL rem_ovf got=%h exp=0", res); end
        run_op(F3_DIV, 32'hFFFF_FFF9, 32'd0, 1'b1, res, lat, bok);
        checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_zero_neg got=%h exp=ffffffff", res); end
        run_op(F3_REM, 32'hFFFF_FFF9, 32'd0, 1'b1, res, lat, bok);
        checks++; if (res !== 32'hFFFF_FFF9) begin errors++; $display("FAIL rem_zero_neg got=%h exp=fffffff9", res); end
    endtask

    task automatic test_flush();
        bit seen;
        in_valid = 1'b1; funct3 = F3_MUL; rs1 = 32'd9; rs2 = 32'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got=%b exp=0", busy); end
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; seen = seen | out_valid; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_valid got=%b exp=0", seen); end
        in_valid = 1'b1; flush = 1'b1; funct3 = F3_MUL; rs1 = 32'd1; rs2 = 32'd1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle_no_accept got=%b exp=0", busy); end
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; funct3 = F3_MUL; rs1 = 32'd7; rs2 = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        #1 rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got=%b exp=0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL areset_out_result got=%h exp=0", out_result); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] res; int lat; bit bok;
        run_op(F3_DIVU, 32'd100, 32'd7, 1'b0, res, lat, bok);
        checks++; if (res !== 32'd14) begin errors++; $display("FAIL hold_first got=%h exp=e", res); end
        in_valid = 1'b1; funct3 = F3_MUL; rs1 = 32'd3; rs2 = 32'd5;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid cyc=%0d got=%b exp=1", k, out_valid); end
            checks++; if (out_result !== 32'd14) begin errors++; $display("FAIL hold_result cyc=%0d got=%h exp=e", k, out_result); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready cyc=%0d got=%b exp=0", k, in_ready); end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pop_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pop_in_ready got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got=%b exp=1", busy); end
        lat = 1;
        while (!out_valid && lat < 60) begin @(posedge clk); #1; lat++; end
        checks++; if (out_result !== 32'd15) begin errors++; $display("FAIL b2b_result got=%h exp=f", out_result); end
        checks++; if (lat !== 34) begin errors++; $display("FAIL b2b_latency got=%0d exp=34", lat); end
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL done_flush_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL done_flush_in_ready got=%b exp=1", in_ready); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        funct3    = 3'b000;
        rs1       = '0;
        rs2       = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_async_reset();
        test_flush();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
